muldiv_unit: RTL and testbench

Iterative multiply/divide unit. It consumes the latched A and B operand registers that feed the ALU stage and produces the HI/LO result pair, using a start/busy/done handshake with the multi-cycle control FSM. It supports unsigned and signed multiply and divide, plus direct HI/LO writes (MTHI/MTLO). Results are read from the hi/lo outputs, which the control FSM uses for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 15 +
 rtl/muldiv_unit.sv | 110 +++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM state type and sizing helper for the multiply/divide unit
package muldiv_pkg;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative signed/unsigned multiply and restoring divide producing the HI/LO pair
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = cnt_width(WIDTH);

    state_t             state, next_state;
    logic [CW-1:0]      count;
    logic [1:0]         op_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvs;
    logic               sign_a, sign_b, zero_b;
    logic               is_div, is_signed, neg_res, fix_write;
    logic [WIDTH:0]     alu_a, alu_out;
    logic [2*WIDTH-1:0] acc_step, prod_fix;
    logic [WIDTH-1:0]   q_fix, r_fix, mag_a, mag_b;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state: IDLE waits for start, CALC runs WIDTH steps, FIX lasts one cycle
    always_comb begin
        next_state = state;
        next_state = (state == IDLE) ? (start ? CALC : IDLE) :
                     (state == CALC) ? ((count == CW'(WIDTH - 1)) ? FIX : CALC) : IDLE;
    end

    // FSM outputs: busy covers CALC and FIX; divide-by-zero suppresses the result write
    always_comb begin
        busy      = (state != IDLE);
        fix_write = (state == FIX) && !(is_div && zero_b);
    end

    // Shared adder/subtractor step and final sign correction
    always_comb begin
        is_div    = op_q[1];
        is_signed = op_q[0];
        neg_res   = is_signed && (sign_a ^ sign_b);
        mag_a     = (op[0] && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b     = (op[0] && in_b[WIDTH-1]) ? -in_b : in_b;
        alu_a     = is_div ? acc[2*WIDTH-1:WIDTH-1] : {1'b0, acc[2*WIDTH-1:WIDTH]};
        alu_out   = is_div ? alu_a - {1'b0, dvs} : alu_a + {1'b0, dvs};
        acc_step  = is_div ? (alu_out[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                             : {alu_out[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                           : (acc[0] ? {alu_out, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
        prod_fix  = neg_res ? -acc : acc;
        q_fix     = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        r_fix     = (is_signed && sign_a) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    // Datapath: operand capture, iteration, result write-back and direct HI/LO writes
    always_ff @(posedge clk) begin
        if (reset) begin
            count       <= '0;
            op_q        <= OP_MULTU;
            acc         <= '0;
            dvs         <= '0;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            zero_b      <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            done        <= (state == FIX);
            div_by_zero <= (state == FIX) && is_div && zero_b;
            if (state == IDLE) begin
                if (wr_hi) hi <= wr_data;
                if (wr_lo) lo <= wr_data;
                if (start) begin
                    op_q   <= op;
                    sign_a <= op[0] && in_a[WIDTH-1];
                    sign_b <= op[0] && in_b[WIDTH-1];
                    zero_b <= (in_b == '0);
                    acc    <= {{WIDTH{1'b0}}, op[1] ? mag_a : mag_b};
                    dvs    <= op[1] ? mag_b : mag_a;
                    count  <= '0;
                end
            end else if (state == CALC) begin
                acc   <= acc_step;
                count <= count + CW'(1);
            end else if (fix_write) begin
                {hi, lo} <= is_div ? {r_fix, q_fix} : prod_fix;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in_a = '0, in_b = '0, wr_data = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          n_cmp = 0, n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: full-precision integer arithmetic on sign- or zero-extended operands
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint x, y;
        logic [63:0] p;
        e.dz = 1'b0;
        e.hi = m_hi;
        e.lo = m_lo;
        x = o[0] ? longint'($signed(a)) : longint'({32'b0, a});
        y = o[0] ? longint'($signed(b)) : longint'({32'b0, b});
        if (!o[1]) begin
            p = 64'(x * y);
            e.hi = p[63:32];
            e.lo = p[31:0];
        end else if (b == 32'd0) begin
            e.dz = 1'b1;
        end else begin
            e.lo = 32'(x / y);
            e.hi = 32'(x % y);
        end
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse pops one expected result
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("hi", hi, mon_e.hi);
                check("lo", lo, mon_e.lo);
                check("div_by_zero", div_by_zero, mon_e.dz);
                check("busy_in_done", busy, 64'd0);
            end
        end
        if (!reset && div_by_zero && !done) check("dz_without_done", 64'd1, 64'd0);
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic wh = 1'b0, input logic wl = 1'b0, input logic [31:0] wd = '0);
        exp_t e;
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        e = model(o, a, b);
        if (!e.dz) begin
            m_hi = e.hi;
            m_lo = e.lo;
        end
        sb.push_back(e);
        start = 1'b1; op = o; in_a = a; in_b = b;
        wr_hi = wh; wr_lo = wl; wr_data = wd;
        @(posedge clk);
        #1;
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        in_a = $urandom; in_b = $urandom;
    endtask

    task automatic wait_done(input bit disturb, output int lat, output int bcnt);
        lat = 0;
        bcnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            lat++;
            if (disturb && j == 5)  begin start = 1'b1; op = 2'b00; in_a = 32'd99; in_b = 32'd7; end
            if (disturb && j == 6)  start = 1'b0;
            if (disturb && j == 10) begin wr_lo = 1'b1; wr_data = 32'h0000_DEAD; end
            if (disturb && j == 11) wr_lo = 1'b0;
            if (done) return;
            if (busy) bcnt++;
        end
        check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_write(input logic wh, input logic wl, input logic [31:0] wd);
        wr_hi = wh; wr_lo = wl; wr_data = wd;
        @(posedge clk);
        #1;
        wr_hi = 1'b0; wr_lo = 1'b0;
        if (wh) m_hi = wd;
        if (wl) m_lo = wd;
        @(negedge clk);
        check("wr_hi_val", hi, m_hi);
        check("wr_lo_val", lo, m_lo);
        check("wr_no_done", done, 64'd0);
    endtask

    initial begin
        int lat, bc;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 64'd0);
        check("rst_done", done, 64'd0);
        check("rst_dz", div_by_zero, 64'd0);
        check("rst_hi", hi, 64'd0);
        check("rst_lo", lo, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bc);
        check("multu_latency", lat, 64'd34);
        check("multu_busy_cycles", bc, 64'd33);
        check("multu_hi_const", hi, 64'hFFFF_FFFE);
        check("multu_lo_const", lo, 64'h0000_0001);

        @(negedge clk);
        issue(2'b01, 32'hFFFF_FFFD, 32'd5);
        wait_done(1'b0, lat, bc);
        check("mult_lo_const", lo, 64'hFFFF_FFF1);
        issue(2'b11, 32'hFFFF_FFF9, 32'd2);
        wait_done(1'b0, lat, bc);
        check("b2b_div_latency", lat, 64'd34);
        check("div_lo_const", lo, 64'hFFFF_FFFD);
        check("div_hi_const", hi, 64'hFFFF_FFFF);

        @(negedge clk);
        issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, bc);
        check("ovf_lo_const", lo, 64'h8000_0000);
        check("ovf_dz", div_by_zero, 64'd0);

        @(negedge clk);
        do_write(1'b1, 1'b0, 32'h0000_1234);
        do_write(1'b0, 1'b1, 32'h0000_5678);
        issue(2'b10, 32'd100, 32'd0);
        wait_done(1'b0, lat, bc);
        check("dz_latency", lat, 64'd34);
        check("dz_flag_const", div_by_zero, 64'd1);
        check("dz_hi_const", hi, 64'h0000_1234);

        @(negedge clk);
        issue(2'b10, 32'd10, 32'd3);
        wait_done(1'b1, lat, bc);
        check("disturb_latency", lat, 64'd34);
        check("disturb_lo_const", lo, 64'd3);
        check("disturb_hi_const", hi, 64'd1);

        @(negedge clk);
        issue(2'b00, $urandom, $urandom);
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 64'd0);
        check("midrst_done", done, 64'd0);
        check("midrst_hi", hi, 64'd0);
        check("midrst_lo", lo, 64'd0);
        sb.delete();
        m_hi = '0;
        m_lo = '0;
        reset = 1'b0;
        @(negedge clk);
        issue(2'b00, 32'd12345, 32'd678);
        wait_done(1'b0, lat, bc);
        check("post_rst_latency", lat, 64'd34);

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) do_write($urandom_range(0, 1) == 1, 1'b1, $urandom);
            ro = 2'($urandom);
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 5) == 0) issue(ro, ra, rb, 1'b1, $urandom_range(0, 1) == 1, $urandom);
            else                           issue(ro, ra, rb);
            wait_done(1'b0, lat, bc);
            if (lat != 34) check("rand_latency", lat, 64'd34);
        end

        @(negedge clk);
        check("scoreboard_drained", sb.size(), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
